// File: rtl/serial_par_buffer_pkg.sv
// serial_par_pkg: shared types and helpers for the serial-to-parallel frame
// buffer (FSM state encoding, count-width helper).
package serial_par_pkg;

    // Buffer FSM: FILL collects samples, PRESENT holds a complete frame.
    typedef enum logic {
        FILL    = 1'b0,
        PRESENT = 1'b1
    } spb_state_e;

    // Width of a counter that must reach DEPTH inclusive.
    function automatic int spb_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/serial_par_buffer_if.sv
// serial_par_buffer_if: producer/consumer handshake bundle for the buffer.
// master = environment side (drives samples, flush and frame ready),
// slave  = the buffer itself.
interface serial_par_buffer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 80
);
    import serial_par_pkg::*;

    localparam int CNT_W = spb_cnt_w(DEPTH);

    logic                   clear;
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [DEPTH*WIDTH-1:0] out_data;
    logic [CNT_W-1:0]       count;
    logic                   drop_err;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, drop_err
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, drop_err
    );

endinterface

// File: rtl/serial_par_buffer_store.sv
// spb_store: sample entry array for serial_par_buffer. Supports an indexed
// write of one sample, a down-shift by STEP entries, and a flattened frame
// output that reads as zero unless 'show' is high. Entries are never reset;
// the controller only exposes them once all DEPTH slots have been written.
module spb_store #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 80,
    parameter int STEP  = 1,
    parameter int IDX_W = 7
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   shift_en,
    input  logic                   show,
    output logic [DEPTH*WIDTH-1:0] frame
);

    logic [DEPTH-1:0][WIDTH-1:0] entry;
    logic [DEPTH-1:0][WIDTH-1:0] entry_d;
    logic [DEPTH*WIDTH-1:0]      flat;
    logic [DEPTH*WIDTH-1:0]      shifted;

    // entry[0] sits in the low bits, so a right shift moves entry[i+STEP]
    // into entry[i]; the vacated top entries are refilled before reuse.
    assign flat    = entry;
    assign shifted = flat >> (STEP * WIDTH);

    // Next-value selection: shift wins, otherwise a single indexed write.
    always_comb begin
        entry_d = entry;
        if (shift_en) begin
            entry_d = shifted;
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == IDX_W'(i)) entry_d[i] = wr_data;
            end
        end
    end

    // Storage register, deliberately without reset.
    always_ff @(posedge clk) begin
        entry <= entry_d;
    end

    // Frame is masked to zero while a frame is being collected.
    always_comb begin
        frame = '0;
        if (show) frame = flat;
    end

endmodule

// File: rtl/serial_par_buffer.sv
// serial_par_buffer: collects DEPTH serial samples of WIDTH bits and presents
// them as one parallel frame with a valid/ready handshake.
// Build option: define SERIAL_PAR_BUFFER_SLIDE_EN for slide mode, where a
// consumed frame discards only the STEP oldest samples and the next frame is
// ready after STEP more accepts. Without it each frame needs DEPTH fresh
// samples and STEP is ignored.
module serial_par_buffer
    import serial_par_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 80,
    parameter int STEP  = 1
) (
    input logic                clk,
    input logic                rst,
    serial_par_buffer_if.slave bus
);

    localparam int CNT_W = spb_cnt_w(DEPTH);

    spb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_q;
    logic             accept, handshake;
    logic             wr_en, shift_en;
    logic             in_ready, out_valid;

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == PRESENT);
    assign accept    = bus.in_valid && in_ready;
    assign handshake = bus.out_ready && out_valid;

    // Next state / count: clear beats accept and handshake.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        shift_en = 1'b0;
        if (bus.clear) begin
            state_d = FILL;
            cnt_d   = '0;
        end else if (accept) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DEPTH - 1)) state_d = PRESENT;
        end else if (handshake) begin
            state_d = FILL;
`ifdef SERIAL_PAR_BUFFER_SLIDE_EN
            shift_en = 1'b1;
            cnt_d    = CNT_W'(DEPTH - STEP);
`else
            cnt_d    = '0;
`endif
        end
    end

    // State, count and sticky drop flag; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_q | (bus.in_valid & ~in_ready);
        end
    end

    spb_store #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .STEP  (STEP),
        .IDX_W (CNT_W)
    ) u_store (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_idx   (cnt_q),
        .wr_data  (bus.in_data),
        .shift_en (shift_en),
        .show     (out_valid),
        .frame    (bus.out_data)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.count     = cnt_q;
    assign bus.drop_err  = drop_q;

endmodule

// File: tb/tb_serial_par_buffer.sv
// tb_serial_par_buffer: directed scenarios plus randomized traffic against a
// queue-based reference model of serial_par_buffer (WIDTH=8, DEPTH=4, STEP=1).
module tb_serial_par_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int STEP  = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: the stored samples in arrival order plus the drop flag.
    logic [WIDTH-1:0] mq[$];
    bit               mdrop = 1'b0;

    serial_par_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    serial_par_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STEP(STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference behaviour of one clock edge given the inputs of that cycle.
    task automatic model_edge(input bit r, input bit c, input bit iv,
                              input logic [WIDTH-1:0] d, input bit ordy);
        if (r) begin
            mq.delete();
            mdrop = 1'b0;
            return;
        end
        if (iv && mq.size() == DEPTH) mdrop = 1'b1;
        if (c) begin
            mq.delete();
        end else if (iv && mq.size() < DEPTH) begin
            mq.push_back(d);
        end else if (ordy && mq.size() == DEPTH) begin
`ifdef SERIAL_PAR_BUFFER_SLIDE_EN
            repeat (STEP) void'(mq.pop_front());
`else
            mq.delete();
`endif
        end
    endtask

    function automatic logic [DEPTH*WIDTH-1:0] exp_frame();
        logic [DEPTH*WIDTH-1:0] f = '0;
        if (mq.size() == DEPTH)
            for (int i = 0; i < DEPTH; i++) f[WIDTH*i +: WIDTH] = mq[i];
        return f;
    endfunction

    // One clock: apply inputs, advance the model at the edge, settle 1 time unit.
    task automatic cyc(input bit r, input bit c, input bit iv,
                       input logic [WIDTH-1:0] d, input bit ordy);
        rst           = r;
        bus.clear     = c;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        @(posedge clk);
        model_edge(r, c, iv, d, ordy);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
            n_tests++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.count !== '0 ||
                bus.out_data !== '0 || bus.drop_err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset[%0d]: in_ready=%b out_valid=%b count=%0d out_data=%h drop_err=%b, want 1 0 0 0 0",
                         i, bus.in_ready, bus.out_valid, bus.count, bus.out_data, bus.drop_err);
            end
        end
    endtask

    task automatic test_fill();
        logic [WIDTH-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b1, vals[i], 1'b0);
            if (i < 3) begin
                n_tests++;
                if (bus.count !== 3'(i + 1) || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
                    n_fail++;
                    $display("FAIL fill_partial[%0d]: count=%0d out_valid=%b out_data=%h, want %0d 0 0",
                             i, bus.count, bus.out_valid, bus.out_data, i + 1);
                end
            end
        end
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h44332211 || bus.count !== 3'd4 ||
            bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: out_valid=%b out_data=%h count=%0d in_ready=%b, want 1 44332211 4 0",
                     bus.out_valid, bus.out_data, bus.count, bus.in_ready);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0);
            n_tests++;
            if (bus.out_data !== 32'h44332211 || bus.drop_err !== 1'b1 ||
                bus.out_valid !== 1'b1 || bus.count !== 3'd4) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: out_data=%h drop_err=%b out_valid=%b count=%0d, want 44332211 1 1 4",
                         i, bus.out_data, bus.drop_err, bus.out_valid, bus.count);
            end
        end
    endtask

    task automatic test_slide();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.count !== 3'(mq.size())) begin
            n_fail++;
            $display("FAIL handshake: out_valid=%b in_ready=%b count=%0d, want 0 1 %0d",
                     bus.out_valid, bus.in_ready, bus.count, mq.size());
        end
        cyc(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        n_tests++;
`ifdef SERIAL_PAR_BUFFER_SLIDE_EN
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h55443322 || bus.count !== 3'd4) begin
            n_fail++;
            $display("FAIL slide: out_valid=%b out_data=%h count=%0d, want 1 55443322 4",
                     bus.out_valid, bus.out_data, bus.count);
        end
`else
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd1 || bus.out_data !== '0) begin
            n_fail++;
            $display("FAIL refill: out_valid=%b count=%0d out_data=%h, want 0 1 0",
                     bus.out_valid, bus.count, bus.out_data);
        end
`endif
    endtask

    task automatic test_priority();
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0);
        n_tests++;
        if (bus.count !== 3'd2) begin
            n_fail++;
            $display("FAIL prio_midfill: count=%0d, want 2", bus.count);
        end
        cyc(1'b1, 1'b1, 1'b1, 8'hA3, 1'b1);
        n_tests++;
        if (bus.count !== 3'd0 || bus.drop_err !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_rst_clear: count=%0d drop_err=%b in_ready=%b, want 0 0 1",
                     bus.count, bus.drop_err, bus.in_ready);
        end
        // clear beats an accept in the same cycle
        cyc(1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
        n_tests++;
        if (bus.count !== 3'd0) begin
            n_fail++;
            $display("FAIL prio_clear_accept: count=%0d, want 0", bus.count);
        end
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
        n_tests++;
        if (bus.drop_err !== 1'b1 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_drop_set: drop_err=%b out_valid=%b, want 1 1", bus.drop_err, bus.out_valid);
        end
        // clear beats a handshake and leaves drop_err alone
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        n_tests++;
        if (bus.count !== 3'd0 || bus.drop_err !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            n_fail++;
            $display("FAIL prio_clear_sticky: count=%0d drop_err=%b out_valid=%b out_data=%h, want 0 1 0 0",
                     bus.count, bus.drop_err, bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 150) == 0, ($urandom % 40) == 0, ($urandom % 4) != 0,
                8'($urandom), ($urandom % 3) == 0);
            n_tests++;
            if (bus.count !== 3'(mq.size()) || bus.in_ready !== (mq.size() < DEPTH) ||
                bus.out_valid !== (mq.size() == DEPTH) || bus.out_data !== exp_frame() ||
                bus.drop_err !== mdrop) begin
                n_fail++;
                $display("FAIL random[%0d]: count=%0d/%0d in_ready=%b out_valid=%b out_data=%h/%h drop_err=%b/%b",
                         i, bus.count, mq.size(), bus.in_ready, bus.out_valid,
                         bus.out_data, exp_frame(), bus.drop_err, mdrop);
            end
        end
    endtask

    initial begin
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_fill();
        test_backpressure();
        test_slide();
        test_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
